traffic_demand_sensor: RTL
==========================

// Module: traffic_demand_sensor
// PURPOSE
//  Upstream front end of the intersection light controller.
//  - Conditions raw loop-detector, push-button and emergency inputs.
//  - Keeps a saturating 3-bit demand count per lane: main, left, secondary, pedestrian.
//  - Drives the controller inputs: main_num, left_num, sec_num, p_num, m_emergency, s_emergency,
//    plus the threshold flags it uses for green-time selection.
// PARAMETERS
//  DB_CYC      4   consecutive stable synced samples needed to change a debounced input (>=1)
//  DEPART_CYC  8   cycles of green per served unit; one count is removed per DEPART_CYC (>=2)
//  EM_HOLD     16  minimum cycles an emergency output stays asserted after its trigger (>=1)
//  MORE_TH     5   count at or above which the lane's more_flag is set (1..7)
// PORTS
//  clk          in   1  clock
//  rst          in   1  asynchronous active-high reset
//  sens_raw     in   4  async arrival sensors, bit0=main, 1=left, 2=sec, 3=ped; a level high = vehicle/button present
//  lane_go      in   4  sync, same lane order; 1 = lane currently has green/walk (fed back from controller lights)
//  m_em_raw     in   1  async main-road emergency request
//  s_em_raw     in   1  async secondary-road emergency request
//  main_num     out  3  main-road demand count
//  left_num     out  3  left-turn demand count
//  sec_num      out  3  secondary-road demand count
//  p_num        out  3  pedestrian demand count
//  more_flag    out  4  per lane, count >= MORE_TH (registered with counts)
//  l_zero       out  1  left_num == 0
//  m_emergency  out  1  main emergency active
//  s_emergency  out  1  secondary emergency active (masked by main)
// BEHAVIOUR
//  Reset
//  - Every output 0, except l_zero=1.
//  - All sync flops, debounce state and counters, depart timers and emergency FSMs cleared.
//  - Reset mid-operation discards all pending counts and holds immediately.
//
//  Input conditioning (all 6 raw inputs: sens_raw[3:0], m_em_raw, s_em_raw)
//  - 2-flop synchronizer, then debounce.
//  - Debounce: stability counter increments while the synced value differs from the debounced value,
//    and clears while they agree.
//  - On reaching DB_CYC, the debounced value flips and the counter clears.
//  - Glitches shorter than DB_CYC cycles are ignored.
//
//  Arrival
//  - A debounced rising edge of sens[i] produces inc[i] for one cycle.
//  - Count updates on the next edge.
//  - Raw held high from edge 0: count visible after edge 3+DB_CYC.
//
//  Departure
//  - Per-lane timer runs while lane_go[i]=1 and count[i]!=0.
//  - When the timer reaches DEPART_CYC-1: dec[i] for one cycle, timer restarts at 0.
//  - Timer clears whenever lane_go[i]=0 or count[i]==0.
//  - First departure occurs DEPART_CYC cycles after lane_go rises.
//
//  Count update (3-bit, per lane)
//  - inc&~dec: +1, saturate at 7.
//  - dec&~inc: -1, floor at 0.
//  - inc&dec: unchanged (including at 0 and at 7).
//  - No wrap-around ever.
//
//  more_flag / l_zero
//  - Derived from the next count value and registered, so they change in the same cycle as the counts.
//
//  Emergency FSM, one per road (states IDLE, ACTIVE)
//  - IDLE -> ACTIVE on debounced rising edge; hold counter loads 0.
//  - ACTIVE: hold counter increments, saturating at EM_HOLD.
//  - ACTIVE -> IDLE when hold==EM_HOLD and debounced request is low.
//  - A new rising edge while ACTIVE reloads the hold counter to 0.
//  - Output is registered: em = (state==ACTIVE).
//  - s_emergency = s_active & ~m_active; the secondary FSM keeps running while masked,
//    so s_emergency reappears when main clears if s is still ACTIVE.
//  - Simultaneous main and secondary triggers: only m_emergency asserts.
// TESTING
//  - Reset: assert rst mid-count with main_num=5 -> all counts 0, l_zero=1, emergencies 0 asynchronously.
//  - Debounce: sens_raw[0] pulse of 3 cycles (DB_CYC=4) -> main_num stays 0.
//    Held pulse -> main_num=1 exactly 7 cycles after rise.
//  - Saturation: 9 debounced arrivals on sec lane -> sec_num=7, more_flag[2]=1.
//    With lane_go[2]=1 for 64 cycles -> sec_num=0 at cycle 56+, no underflow, more_flag[2] clears at 4.
//  - Simultaneous: left_num=3, arrival edge coincides with dec -> left_num stays 3.
//    At left_num=7 with inc&dec -> stays 7.
//  - Emergency hold: m_em_raw high 2 debounced cycles -> m_emergency high >=16 cycles then low.
//    Retrigger during hold extends it.
//  - Priority: m and s raw rise together -> m_emergency=1, s_emergency=0.
//    After main clears with s still requested -> s_emergency=1.

Source files
------------

// File: rtl/traffic_demand_sensor.sv
// Front end of the intersection light controller: conditions raw sensor and emergency
// inputs, keeps a saturating per-lane demand count and drives the emergency request outputs.
module traffic_demand_sensor #(
  parameter int unsigned DB_CYC     = 4,
  parameter int unsigned DEPART_CYC = 8,
  parameter int unsigned EM_HOLD    = 16,
  parameter int unsigned MORE_TH    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sens_raw,
  input  logic [3:0] lane_go,
  input  logic       m_em_raw,
  input  logic       s_em_raw,
  output logic [2:0] main_num,
  output logic [2:0] left_num,
  output logic [2:0] sec_num,
  output logic [2:0] p_num,
  output logic [3:0] more_flag,
  output logic       l_zero,
  output logic       m_emergency,
  output logic       s_emergency
);

  localparam int unsigned DBW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int unsigned TW  = $clog2(DEPART_CYC);
  localparam int unsigned HW  = $clog2(EM_HOLD + 1);

  typedef enum logic {EM_IDLE, EM_ACTIVE} em_state_t;

  logic [5:0]     raw, sync1, sync2, deb, deb_q, rise;
  logic [DBW-1:0] db_cnt [6];

  logic [2:0]     cnt    [4];
  logic [2:0]     cnt_nx [4];
  logic [TW-1:0]  tmr    [4];
  logic [3:0]     dec;

  em_state_t      em_st    [2];
  em_state_t      em_st_nx [2];
  logic [HW-1:0]  hold     [2];
  logic [HW-1:0]  hold_nx  [2];

  // bits 3:0 = lane sensors, 4 = main emergency, 5 = secondary emergency
  assign raw = {s_em_raw, m_em_raw, sens_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      rise  <= '0;
      for (int unsigned i = 0; i < 6; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      rise  <= deb & ~deb_q;
      for (int unsigned i = 0; i < 6; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DB_CYC - 1)) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A coincident arrival and departure cancel, so the count holds even at 0 or 7.
  always_comb begin
    for (int unsigned l = 0; l < 4; l++) begin
      dec[l]    = lane_go[l] && (cnt[l] != 3'd0) && (tmr[l] == TW'(DEPART_CYC - 1));
      cnt_nx[l] = cnt[l];
      if (rise[l] && !dec[l] && (cnt[l] != 3'd7))
        cnt_nx[l] = cnt[l] + 3'd1;
      else if (dec[l] && !rise[l] && (cnt[l] != 3'd0))
        cnt_nx[l] = cnt[l] - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned l = 0; l < 4; l++) begin
        cnt[l] <= '0;
        tmr[l] <= '0;
      end
      more_flag <= '0;
      l_zero    <= 1'b1;
    end else begin
      for (int unsigned l = 0; l < 4; l++) begin
        cnt[l]       <= cnt_nx[l];
        more_flag[l] <= (cnt_nx[l] >= 3'(MORE_TH));
        if (!lane_go[l] || (cnt[l] == 3'd0) || dec[l])
          tmr[l] <= '0;
        else
          tmr[l] <= tmr[l] + 1'b1;
      end
      l_zero <= (cnt_nx[1] == 3'd0);
    end
  end

  assign main_num = cnt[0];
  assign left_num = cnt[1];
  assign sec_num  = cnt[2];
  assign p_num    = cnt[3];

  // r = 0 main road, r = 1 secondary road; a retrigger while active restarts the hold
  always_comb begin
    for (int unsigned r = 0; r < 2; r++) begin
      em_st_nx[r] = em_st[r];
      hold_nx[r]  = hold[r];
      unique case (em_st[r])
        EM_IDLE: begin
          if (rise[4+r]) begin
            em_st_nx[r] = EM_ACTIVE;
            hold_nx[r]  = '0;
          end
        end
        EM_ACTIVE: begin
          if (rise[4+r]) begin
            hold_nx[r] = '0;
          end else if (hold[r] == HW'(EM_HOLD)) begin
            if (!deb[4+r]) em_st_nx[r] = EM_IDLE;
          end else begin
            hold_nx[r] = hold[r] + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < 2; r++) begin
        em_st[r] <= EM_IDLE;
        hold[r]  <= '0;
      end
      m_emergency <= 1'b0;
      s_emergency <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < 2; r++) begin
        em_st[r] <= em_st_nx[r];
        hold[r]  <= hold_nx[r];
      end
      m_emergency <= (em_st_nx[0] == EM_ACTIVE);
      s_emergency <= (em_st_nx[1] == EM_ACTIVE) && (em_st_nx[0] != EM_ACTIVE);
    end
  end

endmodule
